// File: rtl/phy_rx_link_ctrl_if.sv
// rtl/phy_rx_link_ctrl_if.sv - byte-side bus between the deserializer and the rx link controller
interface phy_rx_link_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       data_in;
    logic             resync;
    logic             active;
    logic [7:0]       data_out;
    logic             valid_out;
    logic [1:0]       state_out;
    logic [CNT_W-1:0] data_count;

    modport master (
        output data_in,
        output resync,
        input  active,
        input  data_out,
        input  valid_out,
        input  state_out,
        input  data_count
    );

    modport slave (
        input  data_in,
        input  resync,
        output active,
        output data_out,
        output valid_out,
        output state_out,
        output data_count
    );
endinterface

// File: rtl/phy_rx_link_ctrl.sv
// rtl/phy_rx_link_ctrl.sv - rx link training FSM with data forwarding and COM/IDL filtering
module phy_rx_link_ctrl #(
    parameter logic [7:0] COM_SYM    = 8'hBC,
    parameter logic [7:0] IDL_SYM    = 8'h7C,
    parameter int         COM_NEEDED = 4,
    parameter int         IDL_NEEDED = 1,
    parameter int         CNT_W      = 16
) (
    input  logic               clk_4f,
    input  logic               reset_L,
    phy_rx_link_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        SEARCH   = 2'd0,
        COM_LOCK = 2'd1,
        IDL_WAIT = 2'd2,
        ACTIVE   = 2'd3
    } state_t;

    localparam logic [3:0] COM_N = 4'(COM_NEEDED);
    localparam logic [3:0] IDL_N = 4'(IDL_NEEDED);

    state_t           state, state_n;
    logic [3:0]       com_run, com_run_n;
    logic [3:0]       idl_run, idl_run_n;
    logic [7:0]       data_q, data_n;
    logic             valid_q, valid_n;
    logic             active_q;
    logic [CNT_W-1:0] cnt_q, cnt_n;

    logic is_com, is_idl;
    assign is_com = (bus.data_in == COM_SYM);
    assign is_idl = (bus.data_in == IDL_SYM);

    // State and output registers; active is derived from the next state so it rises with the final IDL
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state    <= SEARCH;
            com_run  <= 4'd0;
            idl_run  <= 4'd0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state    <= state_n;
            com_run  <= com_run_n;
            idl_run  <= idl_run_n;
            data_q   <= data_n;
            valid_q  <= valid_n;
            active_q <= (state_n == ACTIVE);
            cnt_q    <= cnt_n;
        end
    end

    // Next-state, run counters and data path; resync takes priority over every training rule
    always_comb begin
        state_n   = state;
        com_run_n = com_run;
        idl_run_n = idl_run;
        data_n    = data_q;
        valid_n   = 1'b0;
        cnt_n     = cnt_q;

        case (state)
            SEARCH: begin
                if (is_com) begin
                    com_run_n = 4'd1;
                    idl_run_n = 4'd0;
                    state_n   = (COM_N == 4'd1) ? IDL_WAIT : COM_LOCK;
                end
            end
            COM_LOCK: begin
                if (is_com) begin
                    com_run_n = com_run + 4'd1;
                    if (com_run_n == COM_N) begin
                        state_n   = IDL_WAIT;
                        idl_run_n = 4'd0;
                    end
                end else begin
                    com_run_n = 4'd0;
                    state_n   = SEARCH;
                end
            end
            IDL_WAIT: begin
                if (is_idl) begin
                    idl_run_n = idl_run + 4'd1;
                    if (idl_run_n == IDL_N) begin
                        state_n   = ACTIVE;
                        com_run_n = 4'd0;
                        cnt_n     = '0;
                    end
                end else if (is_com) begin
                    idl_run_n = 4'd0;
                end else begin
                    state_n   = SEARCH;
                    com_run_n = 4'd0;
                    idl_run_n = 4'd0;
                end
            end
            ACTIVE: begin
                if (is_com) begin
                    com_run_n = com_run + 4'd1;
                    if (com_run_n == COM_N) begin
                        state_n   = IDL_WAIT;
                        com_run_n = 4'd0;
                        idl_run_n = 4'd0;
                    end
                end else if (is_idl) begin
                    com_run_n = 4'd0;
                end else begin
                    com_run_n = 4'd0;
                    data_n    = bus.data_in;
                    valid_n   = 1'b1;
                    cnt_n     = cnt_q + 1'b1;
                end
            end
            default: state_n = SEARCH;
        endcase

        if (bus.resync) begin
            state_n   = SEARCH;
            com_run_n = 4'd0;
            idl_run_n = 4'd0;
            valid_n   = 1'b0;
            data_n    = data_q;
            cnt_n     = cnt_q;
        end
    end

    assign bus.active     = active_q;
    assign bus.data_out   = data_q;
    assign bus.valid_out  = valid_q;
    assign bus.state_out  = state;
    assign bus.data_count = cnt_q;
endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// tb/tb_phy_rx_link_ctrl.sv - directed self-checking bench for phy_rx_link_ctrl
module tb_phy_rx_link_ctrl;
    localparam int CW = 4;

    logic clk_4f  = 1'b0;
    logic reset_L = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    phy_rx_link_ctrl_if #(.CNT_W(CW)) bus ();

    phy_rx_link_ctrl #(
        .COM_SYM    (8'hBC),
        .IDL_SYM    (8'h7C),
        .COM_NEEDED (4),
        .IDL_NEEDED (1),
        .CNT_W      (CW)
    ) dut (
        .clk_4f  (clk_4f),
        .reset_L (reset_L),
        .bus     (bus.slave)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int st, input int act, input int vld,
                           input int dout, input int cnt);
        check_eq({tag, ".state"},  32'(bus.state_out),  32'(st));
        check_eq({tag, ".active"}, 32'(bus.active),     32'(act));
        check_eq({tag, ".valid"},  32'(bus.valid_out),  32'(vld));
        check_eq({tag, ".dout"},   32'(bus.data_out),   32'(dout));
        check_eq({tag, ".cnt"},    32'(bus.data_count), 32'(cnt));
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_4f);
        bus.data_in = b;
        @(posedge clk_4f);
        #1;
    endtask

    initial begin
        bus.data_in = 8'h00;
        bus.resync  = 1'b0;
        #12;
        chk_out("reset", 0, 0, 0, 8'h00, 0);
        @(negedge clk_4f);
        reset_L = 1'b1;

        // training: 4 COMs then 1 IDL
        send_byte(8'hBC); chk_out("train_c1", 1, 0, 0, 0, 0);
        send_byte(8'hBC); chk_out("train_c2", 1, 0, 0, 0, 0);
        send_byte(8'hBC); chk_out("train_c3", 1, 0, 0, 0, 0);
        send_byte(8'hBC); chk_out("train_c4", 2, 0, 0, 0, 0);
        send_byte(8'h7C); chk_out("train_idl", 3, 1, 0, 0, 0);

        // data forwarding with IDL filtered
        send_byte(8'h11); chk_out("data_11", 3, 1, 1, 8'h11, 1);
        send_byte(8'h7C); chk_out("data_idl", 3, 1, 0, 8'h11, 1);
        send_byte(8'h22); chk_out("data_22", 3, 1, 1, 8'h22, 2);

        // short COM run does not retrain, full run does
        send_byte(8'hBC); chk_out("ret_a1", 3, 1, 0, 8'h22, 2);
        send_byte(8'hBC); chk_out("ret_a2", 3, 1, 0, 8'h22, 2);
        send_byte(8'hBC); chk_out("ret_a3", 3, 1, 0, 8'h22, 2);
        send_byte(8'h33); chk_out("ret_33", 3, 1, 1, 8'h33, 3);
        send_byte(8'hBC); chk_out("ret_b1", 3, 1, 0, 8'h33, 3);
        send_byte(8'hBC); chk_out("ret_b2", 3, 1, 0, 8'h33, 3);
        send_byte(8'hBC); chk_out("ret_b3", 3, 1, 0, 8'h33, 3);
        send_byte(8'hBC); chk_out("ret_b4", 2, 0, 0, 8'h33, 3);
        send_byte(8'h7C); chk_out("ret_idl", 3, 1, 0, 8'h33, 0);

        // counter wrap with 4-bit width: 17 bytes -> 1
        for (int i = 0; i < 17; i++) begin
            send_byte(8'h40 + 8'(i));
            check_eq($sformatf("wrap_cnt%0d", i), 32'(bus.data_count), 32'((i + 1) % 16));
            check_eq($sformatf("wrap_dout%0d", i), 32'(bus.data_out), 32'(8'h40 + i));
        end

        // resync mid-stream
        @(negedge clk_4f);
        bus.resync  = 1'b1;
        bus.data_in = 8'h66;
        @(posedge clk_4f);
        #1;
        chk_out("resync", 0, 0, 0, 8'h50, 1);
        @(negedge clk_4f);
        bus.resync = 1'b0;

        // aborted lock
        send_byte(8'hBC); chk_out("abort_c1", 1, 0, 0, 8'h50, 1);
        send_byte(8'hBC); chk_out("abort_c2", 1, 0, 0, 8'h50, 1);
        send_byte(8'h55); chk_out("abort_55", 0, 0, 0, 8'h50, 1);
        send_byte(8'hBC); chk_out("abort_c3", 1, 0, 0, 8'h50, 1);
        send_byte(8'h12); chk_out("abort_12", 0, 0, 0, 8'h50, 1);

        // IDL_WAIT: extra COM tolerated, junk byte drops to SEARCH
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        chk_out("iw_lock", 2, 0, 0, 8'h50, 1);
        send_byte(8'hBC); chk_out("iw_extra", 2, 0, 0, 8'h50, 1);
        send_byte(8'h99); chk_out("iw_junk", 0, 0, 0, 8'h50, 1);

        // retrain and async reset during ACTIVE
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        send_byte(8'h7C); chk_out("rt_idl", 3, 1, 0, 8'h50, 0);
        send_byte(8'h5A); chk_out("rt_5a", 3, 1, 1, 8'h5A, 1);
        #2;
        reset_L = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0, 8'h00, 0);
        @(negedge clk_4f);
        reset_L = 1'b1;
        send_byte(8'hBC); chk_out("post_rst", 1, 0, 0, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
